// File: rtl/regfile_mp_pkg.sv
// Purpose : shared defaults and small helpers for the multi-port register file.
// Latency : n/a (package).
// Backpr. : n/a (package).
package regfile_mp_pkg;

  `include "regfile_defs.vh"

  // Index width for a register count; NREGS is a power of two, so every
  // index value addresses a real register.
  function automatic int idx_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_defs.vh
// Default sizing shared by the register file and its users.
// Included inside regfile_mp_pkg so every importer sees the same defaults.
// STRB_W_DEF follows XLEN_DEF so the strobe width never drifts from the data width.
`ifndef REGFILE_DEFS_VH
`define REGFILE_DEFS_VH

localparam int XLEN_DEF   = 32;
localparam int NREGS_DEF  = 32;
localparam int NUM_RD_DEF = 2;
localparam int STRB_W_DEF = XLEN_DEF / 8;

`endif

// File: rtl/regfile_scoreboard.sv
// Purpose : busy scoreboard, one pending bit per architectural register.
// Latency : issue/writeback take effect on busy_vec one cycle later.
// Backpr. : none; issue logic must not over-issue (no WAW counting).
//
// Ports:
//   clk, reset      rising-edge clock, async active-low reset
//   enable, rd      writeback valid and destination (clears pending)
//   issue_valid,    issue with destination (sets pending; wins over a
//   issue_rd        same-cycle clear of the same index)
//   busy_vec        registered pending bits
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter  int NREGS    = NREGS_DEF,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = idx_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] rd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Clear first, then set, so an issue to the register being written back
  // leaves it pending for the new producer.
  always_comb begin
    busy_nxt = busy_q;
    if (enable) begin
      busy_nxt[rd] = 1'b0;
    end
    if (issue_valid) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Purpose : multi-read-port register file, byte-strobed write, bypass, scoreboard.
// Latency : reads combinational (0 cycles); writes visible next cycle, or same cycle with BYPASS.
// Backpr. : none; every writeback and issue is accepted the cycle it is presented.
//
// Ports:
//   clk, reset            rising-edge clock, async active-low reset (clears all)
//   enable/rd/write/wstrb writeback valid, destination, data, byte strobes
//   rs / read             NUM_RD packed read indices / packed read data
//   issue_valid/issue_rd  destination being issued (marked pending)
//   busy                  per read port: source still pending
//   busy_vec              registered scoreboard state
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NUM_RD   = NUM_RD_DEF,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = idx_width(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        rd,
  input  logic [XLEN-1:0]          write,
  input  logic [XLEN/8-1:0]        wstrb,
  input  logic [NUM_RD*ADDR_W-1:0] rs,
  output logic [NUM_RD*XLEN-1:0]   read,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic [NUM_RD-1:0]        busy,
  output logic [NREGS-1:0]         busy_vec
);

  localparam int STRB_W = XLEN / 8;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] wr_merge;
  logic            wr_eff;

  // A writeback to x0 is dropped when x0 is hardwired. Gating with reset keeps
  // the bypass path quiet while reset is held, so every output reads 0.
  assign wr_eff = reset && enable && !((ZERO_REG != 0) && (rd == '0));

  // Byte-merge of incoming data over the current contents of rd. Shared by the
  // array update and the bypass path so both always agree.
  for (genvar b = 0; b < STRB_W; b++) begin : g_merge
    assign wr_merge[8*b +: 8] = wstrb[b] ? write[8*b +: 8] : regs[rd][8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff) begin
      regs[rd] <= wr_merge;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rd          (rd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_vec    (busy_vec)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    logic [ADDR_W-1:0] src;
    logic [XLEN-1:0]   rdat;
    logic              bsy;
    logic              fwd;

    assign src = rs[p*ADDR_W +: ADDR_W];
    assign fwd = (BYPASS != 0) && wr_eff && (rd == src);

    always_comb begin
      rdat = regs[src];
      bsy  = busy_vec[src];
      if ((ZERO_REG != 0) && (src == '0)) begin
        rdat = '0;
        bsy  = 1'b0;
      end else if (fwd) begin
        // The producer is arriving now, so the consumer need not wait.
        rdat = wr_merge;
        bsy  = 1'b0;
      end
    end

    assign read[p*XLEN +: XLEN] = rdat;
    assign busy[p]              = bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk;
  logic        reset;

  // Default-sized instances (bypass on / bypass off) share stimulus.
  logic        enable;
  logic [4:0]  rd;
  logic [31:0] write;
  logic [3:0]  wstrb;
  logic [9:0]  rs;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [63:0] read,     read_nb;
  logic [1:0]  busy,     busy_nb;
  logic [31:0] busy_vec, busy_vec_nb;

  // Wide instance: XLEN=64, NREGS=16, NUM_RD=3.
  logic         w_enable;
  logic [3:0]   w_rd;
  logic [63:0]  w_write;
  logic [7:0]   w_wstrb;
  logic [11:0]  w_rs;
  logic         w_issue_valid;
  logic [3:0]   w_issue_rd;
  logic [191:0] w_read;
  logic [2:0]   w_busy;
  logic [15:0]  w_busy_vec;

  int checks;
  int failures;

  logic [63:0] mref [16];
  logic [15:0] mbv;

  regfile_mp dut (
    .clk(clk), .reset(reset), .enable(enable), .rd(rd), .write(write),
    .wstrb(wstrb), .rs(rs), .read(read), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .busy(busy), .busy_vec(busy_vec)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .enable(enable), .rd(rd), .write(write),
    .wstrb(wstrb), .rs(rs), .read(read_nb), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .busy(busy_nb), .busy_vec(busy_vec_nb)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(3)) dut_w (
    .clk(clk), .reset(reset), .enable(w_enable), .rd(w_rd), .write(w_write),
    .wstrb(w_wstrb), .rs(w_rs), .read(w_read), .issue_valid(w_issue_valid),
    .issue_rd(w_issue_rd), .busy(w_busy), .busy_vec(w_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable      = 1'b0;
    rd          = '0;
    write       = '0;
    wstrb       = '0;
    rs          = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic test_reset_state();
    #2;
    checks++;
    if (read !== 64'h0 || read_nb !== 64'h0) begin
      failures++;
      $display("FAIL reset_read: got %h / %h, want 0", read, read_nb);
    end
    checks++;
    if (busy_vec !== 32'h0 || busy !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy: busy_vec=%h busy=%b, want 0/00", busy_vec, busy);
    end
    checks++;
    if (w_read !== 192'h0 || w_busy_vec !== 16'h0) begin
      failures++;
      $display("FAIL reset_wide: read=%h busy_vec=%h, want 0", w_read, w_busy_vec);
    end
  endtask

  task automatic test_reset_async();
    idle();
    enable = 1'b1; rd = 5'd5; write = 32'hDEADBEEF; wstrb = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    idle();
    rs = {5'd0, 5'd5};
    #2;
    checks++;
    if (read[31:0] !== 32'hDEADBEEF || busy_vec !== 32'h0000_0020 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: read=%h busy_vec=%h busy=%b, want deadbeef/00000020/x1",
               read[31:0], busy_vec, busy);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (read[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_read: got %h, want 0", read[31:0]);
    end
    checks++;
    if (busy_vec !== 32'h0 || busy !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_busy: busy_vec=%h busy=%b, want 0/00", busy_vec, busy);
    end
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_byte_strobe();
    idle();
    enable = 1'b1; rd = 5'd3; write = 32'h11223344; wstrb = 4'hF;
    tick();
    write = 32'hAABBCCDD; wstrb = 4'b0101; rs = {5'd0, 5'd3};
    #2;
    checks++;
    if (read[31:0] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_bypass: got %h, want 11bb33dd", read[31:0]);
    end
    tick();
    idle();
    rs = {5'd3, 5'd3};
    #2;
    checks++;
    if (read !== {32'h11BB33DD, 32'h11BB33DD}) begin
      failures++;
      $display("FAIL strobe_stored: got %h, want 11bb33dd11bb33dd", read);
    end
    // All-zero strobe keeps the data untouched.
    enable = 1'b1; rd = 5'd3; write = 32'hFFFFFFFF; wstrb = 4'h0;
    tick();
    idle();
    rs = {5'd0, 5'd3};
    #2;
    checks++;
    if (read[31:0] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_none: got %h, want 11bb33dd", read[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    enable = 1'b1; rd = 5'd0; write = 32'hFFFFFFFF; wstrb = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd0; rs = {5'd0, 5'd0};
    #2;
    checks++;
    if (read !== 64'h0 || busy !== 2'b00) begin
      failures++;
      $display("FAIL zero_comb: read=%h busy=%b, want 0/00", read, busy);
    end
    tick();
    idle();
    #2;
    checks++;
    if (read !== 64'h0 || read_nb !== 64'h0) begin
      failures++;
      $display("FAIL zero_read: got %h / %h, want 0", read, read_nb);
    end
    checks++;
    if (busy_vec !== 32'h0 || busy_vec_nb !== 32'h0) begin
      failures++;
      $display("FAIL zero_busy_vec: got %h / %h, want 0", busy_vec, busy_vec_nb);
    end
  endtask

  task automatic test_bypass();
    idle();
    enable = 1'b1; rd = 5'd7; write = 32'h1; wstrb = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    enable = 1'b1; rd = 5'd7; write = 32'h2; wstrb = 4'hF; rs = {5'd7, 5'd7};
    #2;
    checks++;
    if (read !== {32'h2, 32'h2} || busy !== 2'b00) begin
      failures++;
      $display("FAIL bypass_on: read=%h busy=%b, want 0000000200000002/00", read, busy);
    end
    checks++;
    if (read_nb !== {32'h1, 32'h1} || busy_nb !== 2'b11) begin
      failures++;
      $display("FAIL bypass_off: read=%h busy=%b, want 0000000100000001/11", read_nb, busy_nb);
    end
    tick();
    idle();
    rs = {5'd7, 5'd7};
    #2;
    checks++;
    if (read_nb !== {32'h2, 32'h2} || busy_nb !== 2'b00 || busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL bypass_after: read=%h busy=%b busy_vec=%h, want 2/2, 00, 0",
               read_nb, busy_nb, busy_vec);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;              // cycle 0
    tick();
    idle();
    rs = {5'd0, 5'd9};
    #2;
    checks++;
    if (busy_vec[9] !== 1'b1 || busy !== 2'b01) begin // cycle 1
      failures++;
      $display("FAIL sb_set: busy_vec[9]=%b busy=%b, want 1/01", busy_vec[9], busy);
    end
    issue_valid = 1'b1; issue_rd = 5'd9;              // WAW re-issue, cycle 1
    tick();
    issue_valid = 1'b0;
    tick();                                           // cycle 3
    tick();                                           // cycle 4
    enable = 1'b1; rd = 5'd9; write = 32'h99; wstrb = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #2;
    checks++;
    if (busy[0] !== 1'b0 || busy_nb[0] !== 1'b1) begin
      failures++;
      $display("FAIL sb_fwd_busy: bypass=%b no_bypass=%b, want 0/1", busy[0], busy_nb[0]);
    end
    tick();                                           // cycle 5
    idle();
    #2;
    checks++;
    if (busy_vec[9] !== 1'b1 || busy_vec_nb[9] !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_wins: got %b/%b, want 1/1", busy_vec[9], busy_vec_nb[9]);
    end
    tick();                                           // cycle 6
    enable = 1'b1; rd = 5'd9; write = 32'h9A; wstrb = 4'hF;
    tick();                                           // cycle 7
    idle();
    #2;
    checks++;
    if (busy_vec !== 32'h0 || busy_vec_nb !== 32'h0) begin
      failures++;
      $display("FAIL sb_clear: got %h/%h, want 0/0", busy_vec, busy_vec_nb);
    end
  endtask

  task automatic test_param_sweep();
    logic [63:0] exp_d;
    logic [63:0] merged;
    logic        exp_b;
    logic [3:0]  s;
    int          bad;
    bad = 0;
    for (int i = 0; i < 16; i++) mref[i] = '0;
    mbv = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      w_enable      = ($urandom_range(0, 3) != 0);
      w_rd          = 4'($urandom_range(0, 15));
      w_write       = {$urandom, $urandom};
      w_wstrb       = 8'($urandom_range(0, 255));
      w_issue_valid = ($urandom_range(0, 2) == 0);
      w_issue_rd    = 4'($urandom_range(0, 15));
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 3) == 0) w_rs[p*4 +: 4] = w_rd;
        else                           w_rs[p*4 +: 4] = 4'($urandom_range(0, 15));
      end
      for (int b = 0; b < 8; b++)
        merged[8*b +: 8] = w_wstrb[b] ? w_write[8*b +: 8] : mref[w_rd][8*b +: 8];
      #2;
      for (int p = 0; p < 3; p++) begin
        s = w_rs[p*4 +: 4];
        if (s == 4'd0) begin
          exp_d = '0; exp_b = 1'b0;
        end else if (w_enable && w_rd == s) begin
          exp_d = merged; exp_b = 1'b0;
        end else begin
          exp_d = mref[s]; exp_b = mbv[s];
        end
        checks++;
        if (w_read[p*64 +: 64] !== exp_d || w_busy[p] !== exp_b) begin
          failures++;
          bad++;
          if (bad <= 10)
            $display("FAIL sweep_port%0d cyc=%0d rs=%0d: read=%h busy=%b, want %h/%b",
                     p, cyc, s, w_read[p*64 +: 64], w_busy[p], exp_d, exp_b);
        end
      end
      checks++;
      if (w_busy_vec !== mbv) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep_busy_vec cyc=%0d: got %h, want %h", cyc, w_busy_vec, mbv);
      end
      if (w_enable && w_rd != 4'd0) mref[w_rd] = merged;
      if (w_enable)      mbv[w_rd] = 1'b0;
      if (w_issue_valid) mbv[w_issue_rd] = 1'b1;
      mbv[0] = 1'b0;
      tick();
    end
    w_enable = 1'b0;
    w_issue_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle();
    w_enable = 1'b0; w_rd = '0; w_write = '0; w_wstrb = '0; w_rs = '0;
    w_issue_valid = 1'b0; w_issue_rd = '0;
    test_reset_state();
    #10;
    reset = 1'b1;
    tick();
    test_reset_async();
    test_byte_strobe();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file with byte-strobed writes, an optional hardwired zero register, and write-to-read bypass.
- Contains an integrated busy scoreboard: an issued destination is marked pending until its writeback arrives.
- Sits between decode/issue and the writeback stage of the core pipeline. It is the next generation of the fixed 32x32, two-read-port register file.

Parameters:
- XLEN, 32, data width in bits; multiple of 8.
- NREGS, 32, number of architectural registers; power of two, ≥ 2.
- ADDR_W, $clog2(NREGS), register index width; derived, not overridden.
- NUM_RD, 2, number of combinational read ports; 1..4.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1, same-cycle writeback data is forwarded to the read ports.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all state.
- enable  input  1  writeback valid (write enable).
- rd  input  ADDR_W  writeback destination index.
- write  input  XLEN  writeback data.
- wstrb  input  XLEN/8  byte write strobes; bit i covers write[8i+7:8i].
- rs  input  NUM_RD*ADDR_W  read indices; port p uses rs[p*ADDR_W +: ADDR_W].
- read  output  NUM_RD*XLEN  read data; port p drives read[p*XLEN +: XLEN].
- issue_valid  input  1  an instruction issued this cycle with a destination.
- issue_rd  input  ADDR_W  destination index to mark busy.
- busy  output  NUM_RD  per read port: the source register is still pending.
- busy_vec  output  NREGS  registered scoreboard state; bit r = register r pending.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers become 0 and busy_vec becomes 0 immediately, without waiting for a clock edge.
  - read and busy follow combinationally, so all outputs are 0 while reset is held.
- Write, at posedge clk:
  - Condition: enable=1, and rd≠0 when ZERO_REG=1.
  - Each byte with wstrb[i]=1 is written; bytes with wstrb[i]=0 are retained.
  - enable=1 with wstrb=0 changes no data but still counts as a writeback for the scoreboard.
- Read (combinational, zero latency), per port p with index s = rs slice:
  - If ZERO_REG and s=0, read = 0.
  - Else if BYPASS and enable=1 and rd=s (and the write is not suppressed by ZERO_REG), read = the byte-merge of write and stored data using wstrb.
  - Otherwise, read = the stored value.
- Ports are independent. Any number of ports may read the same index in the same cycle.
- Scoreboard update, at posedge clk, in this priority order:
  1. enable=1 clears busy_vec[rd].
  2. issue_valid=1 sets busy_vec[issue_rd]; the set wins over a same-cycle clear of the same index.
- WAW handling: the scoreboard does not count.
  - Issuing to an already-busy register leaves it busy.
  - The first subsequent writeback to that register clears it.
  - Ordering of multiple in-flight writes to one register is the issue logic's responsibility.
- ZERO_REG=1: busy_vec[0] is constant 0, and an issue to register 0 is ignored.
- busy[p] (combinational) = busy_vec[s], except:
  - 0 when BYPASS=1 and a same-cycle writeback to s is present (its data is forwarded);
  - 0 when ZERO_REG=1 and s=0.
- BYPASS=0:
  - read returns the old value during the writeback cycle.
  - busy[p] stays 1 until the cycle after the writeback.
- Out-of-range indices cannot occur because NREGS = 2^ADDR_W.

Decomposition:
- Shared include regfile_defs.vh holds the default XLEN, NREGS and NUM_RD, plus a localparam for the strobe width XLEN/8.
- One sub-module: regfile_scoreboard.
  - Inputs: clk, reset, enable, rd, issue_valid, issue_rd.
  - Output: busy_vec.
  - Parameters: NREGS, ZERO_REG.
- The storage array, byte-merge and read/bypass muxing stay in regfile_mp, using generate loops over NUM_RD.

Test Plan:
1. Reset: write 0xDEADBEEF to x5, then pull reset low mid-cycle → read of x5 = 0 before the next edge; busy_vec = 0.
2. Byte strobe: x3 = 0x11223344; write 0xAABBCCDD with wstrb=4'b0101 → the next read of x3 = 0x11BB33DD.
3. Zero register: enable=1, rd=0, write 0xFFFFFFFF; issue_valid with issue_rd=0 → read of x0 = 0; busy_vec[0] = 0.
4. Bypass: x7 = 0x1; in the same cycle, rd=7, write 0x2, rs port0=7 and port1=7 → both ports read 0x2 and busy = 2'b00 combinationally. With BYPASS=0, both read 0x1.
5. Scoreboard: issue x9 at cycle 0 → busy_vec[9]=1 from cycle 1. At cycle 4, writeback to x9 together with issue of x9 → busy_vec[9] stays 1. Writeback at cycle 6 alone → busy_vec[9]=0 at cycle 7.
6. Parameter sweep: XLEN=64, NREGS=16, NUM_RD=3 → perform random writes and reads on all ports against a reference model, 1000 cycles, zero mismatches.
